// File: rtl/bsg_fifo_traffic_gen.sv
// bsg_fifo_traffic_gen
// Closed-loop traffic generator for a ready-then-valid FIFO (e.g. bsg_two_fifo).
// It enqueues a stream whose data is the enqueue sequence number. It dequeues
// with valid-then-yumi and checks data order and FIFO occupancy against its
// own model. The error flags are sticky until reset_i.
//
// Optional feature macro: BSG_FIFO_TRAFFIC_GEN_THROTTLE_EN
//   defined   : LFSR bits 0/1 gate enqueue/dequeue (random bubbles/backpressure)
//   undefined : full-rate streaming; the LFSR still runs but gates nothing
module bsg_fifo_traffic_gen #(
   parameter int          width_p     = 8,
   parameter int          els_p       = 2,
   parameter int          num_items_p = 16,
   parameter logic [15:0] seed_p      = 16'hACE1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               start_i,
   input  logic               ready_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               yumi_o,
   output logic               done_o,
   output logic               error_o,
   output logic [2:0]         err_code_o,
   output logic [31:0]        sent_o,
   output logic [31:0]        recv_o
);

   localparam int               occ_w_lp     = $clog2(els_p + 1);
   localparam logic [occ_w_lp-1:0] occ_full_lp = occ_w_lp'(els_p);
   localparam logic [31:0]      num_items_lp = 32'(num_items_p);
   localparam logic [31:0]      last_item_lp = 32'(num_items_p - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e              state_r;
   logic [31:0]         sent_r;
   logic [31:0]         recv_r;
   logic [occ_w_lp-1:0] occ_r;
   logic [2:0]          err_r;
   logic                error_r;
   logic                done_r;
   logic [15:0]         lfsr_r;

   logic                prod_ok;
   logic                cons_ok;
   logic                enq;
   logic                deq;
   logic                active;
   logic [2:0]          err_set;
   logic                lfsr_fb;

`ifdef BSG_FIFO_TRAFFIC_GEN_THROTTLE_EN
   // Registered LFSR bits throttle both ends, so no ready_i/v_i cross path appears
   assign prod_ok = lfsr_r[0];
   assign cons_ok = lfsr_r[1];
`else
   assign prod_ok = 1'b1;
   assign cons_ok = 1'b1;
`endif

   // Handshakes depend only on registered state plus their own DUT signal
   assign v_o    = (state_r == RUN) & ready_i & prod_ok;
   assign yumi_o = ((state_r == RUN) | (state_r == DRAIN)) & v_i & cons_ok;
   assign enq    = v_o;
   assign deq    = yumi_o;
   assign active = (state_r != IDLE);

   // Per-cycle error events: data order, underflow (valid while empty), overflow
   assign err_set[0] = deq & (data_i != recv_r[width_p-1:0]);
   assign err_set[1] = active & v_i & (occ_r == '0);
   assign err_set[2] = active & enq & (occ_r == occ_full_lp);

   // Fibonacci feedback for taps 16,14,13,11
   assign lfsr_fb = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];

   assign data_o     = sent_r[width_p-1:0];
   assign sent_o     = sent_r;
   assign recv_o     = recv_r;
   assign err_code_o = err_r;
   assign error_o    = error_r;
   assign done_o     = done_r;

   // Run FSM, counters, occupancy model, sticky errors and LFSR
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= IDLE;
         sent_r  <= '0;
         recv_r  <= '0;
         occ_r   <= '0;
         err_r   <= '0;
         error_r <= 1'b0;
         done_r  <= 1'b0;
         lfsr_r  <= seed_p;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values
         if (state_r == RUN || state_r == DRAIN)
            lfsr_r <= {lfsr_r[14:0], lfsr_fb};

         if (enq)
            sent_r <= sent_r + 32'd1;
         if (deq)
            recv_r <= recv_r + 32'd1;

         // A simultaneous enq and deq leaves the occupancy unchanged
         case ({enq, deq})
            2'b10:   occ_r <= occ_r + 1'b1;
            2'b01:   occ_r <= occ_r - 1'b1;
            default: occ_r <= occ_r;
         endcase

         // Errors are recorded but traffic keeps flowing
         err_r   <= err_r | err_set;
         error_r <= error_r | (|err_set);

         case (state_r)
            IDLE: begin
               if (start_i)
                  state_r <= RUN;
            end
            RUN: begin
               // Leave RUN on the edge of the last enqueue so sent stops there
               if (enq && sent_r == last_item_lp)
                  state_r <= DRAIN;
            end
            DRAIN: begin
               if (recv_r == num_items_lp || (deq && recv_r == last_item_lp)) begin
                  state_r <= DONE;
                  done_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= DONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bsg_fifo_traffic_gen.sv
// Testbench for bsg_fifo_traffic_gen in its default (full-rate) build.
// A behavioural two-entry ready-then-valid FIFO closes the loop. It has knobs
// to corrupt one dequeue, assert a spurious valid, hold valid off, or force
// ready high.
module tb_bsg_fifo_traffic_gen;

   localparam int width_lp = 8;
   localparam int items_lp = 16;

   logic                clk;
   logic                reset_i;
   logic                start_i;
   logic                ready_i;
   logic                v_o;
   logic [width_lp-1:0] data_o;
   logic                v_i;
   logic [width_lp-1:0] data_i;
   logic                yumi_o;
   logic                done_o;
   logic                error_o;
   logic [2:0]          err_code_o;
   logic [31:0]         sent_o;
   logic [31:0]         recv_o;

   int tests  = 0;
   int failed = 0;

   // FIFO model state and fault knobs
   logic [width_lp-1:0] mem [2];
   logic                wp;
   logic                rp;
   logic [1:0]          cnt;
   int                  deq_cnt;
   int                  corrupt_at = -1;
   logic                force_rdy  = 1'b0;
   logic                block_v    = 1'b0;
   logic                spur_v     = 1'b0;
   logic                enq_f;
   logic                deq_f;

   logic [width_lp-1:0] exp_q [$];

   bsg_fifo_traffic_gen #(
      .width_p    (width_lp),
      .els_p      (2),
      .num_items_p(items_lp),
      .seed_p     (16'hACE1)
   ) dut (
      .clk_i     (clk),
      .reset_i   (reset_i),
      .start_i   (start_i),
      .ready_i   (ready_i),
      .v_o       (v_o),
      .data_o    (data_o),
      .v_i       (v_i),
      .data_i    (data_i),
      .yumi_o    (yumi_o),
      .done_o    (done_o),
      .error_o   (error_o),
      .err_code_o(err_code_o),
      .sent_o    (sent_o),
      .recv_o    (recv_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign ready_i = (cnt != 2'd2) | force_rdy;
   assign v_i     = spur_v | ((cnt != 2'd0) & ~block_v);
   assign data_i  = mem[rp] ^ {{(width_lp-1){1'b0}}, (deq_cnt == corrupt_at)};
   assign enq_f   = v_o & (cnt != 2'd2);
   assign deq_f   = yumi_o & (cnt != 2'd0);

   // Two-entry FIFO reference, reset together with the generator
   always_ff @(posedge clk) begin
      if (reset_i) begin
         cnt     <= 2'd0;
         wp      <= 1'b0;
         rp      <= 1'b0;
         deq_cnt <= 0;
         mem[0]  <= '0;
         mem[1]  <= '0;
      end else begin
         if (enq_f) begin
            mem[wp] <= data_o;
            wp      <= ~wp;
         end
         if (deq_f) begin
            rp      <= ~rp;
            deq_cnt <= deq_cnt + 1;
         end
         case ({enq_f, deq_f})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_i    = 1'b1;
      start_i    = 1'b0;
      force_rdy  = 1'b0;
      block_v    = 1'b0;
      spur_v     = 1'b0;
      corrupt_at = -1;
      exp_q.delete();
      tick();
      tick();
      reset_i = 1'b0;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      start_i = 1'b1;
      tick();
      tick();
      tests++;
      if ({v_o, yumi_o, done_o, error_o, err_code_o} !== 7'b0) begin
         failed++;
         $display("FAIL reset_ctrl: got %b expected 0000000", {v_o, yumi_o, done_o, error_o, err_code_o});
      end
      tests++;
      if (sent_o !== 32'd0 || recv_o !== 32'd0) begin
         failed++;
         $display("FAIL reset_counts: got sent=%0d recv=%0d expected 0 0", sent_o, recv_o);
      end
      tests++;
      if (data_o !== 8'h00) begin
         failed++;
         $display("FAIL reset_data: got %0h expected 0", data_o);
      end
      start_i = 1'b0;
      reset_i = 1'b0;
      tick();
      tests++;
      if (v_o !== 1'b0 || sent_o !== 32'd0) begin
         failed++;
         $display("FAIL idle_no_enq: got v_o=%0b sent=%0d expected 0 0", v_o, sent_o);
      end
   endtask

   // One complete run; corrupt_idx selects a dequeue to corrupt (-1 = none)
   task automatic run_stream(input int corrupt_idx, input logic [2:0] exp_err);
      logic finished;
      logic chk_err_next;
      logic [width_lp-1:0] exp_d;
      do_reset();
      corrupt_at = corrupt_idx;
      for (int i = 0; i < items_lp; i++)
         exp_q.push_back(width_lp'(i));
      pulse_start();
      tests++;
      if (v_o !== 1'b1 || data_o !== 8'h00) begin
         failed++;
         $display("FAIL first_enq: got v_o=%0b data=%0h expected 1 0", v_o, data_o);
      end
      finished     = 1'b0;
      chk_err_next = 1'b0;
      for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
         if (chk_err_next) begin
            chk_err_next = 1'b0;
            tests++;
            if (err_code_o !== exp_err || error_o !== 1'b1) begin
               failed++;
               $display("FAIL corrupt_flag: got err=%b error=%0b expected %b 1", err_code_o, error_o, exp_err);
            end
         end
         if (v_o && !ready_i) begin
            tests++;
            failed++;
            $display("FAIL v_without_ready: got v_o=1 expected 0");
         end
         if (v_o && ready_i) begin
            tests++;
            if (exp_q.size() == 0) begin
               failed++;
               $display("FAIL extra_enq: got data=%0h expected no enqueue", data_o);
            end else begin
               exp_d = exp_q.pop_front();
               if (data_o !== exp_d) begin
                  failed++;
                  $display("FAIL enq_data: got %0h expected %0h", data_o, exp_d);
               end
            end
         end
         if (yumi_o && corrupt_idx >= 0 && deq_cnt == corrupt_idx) begin
            tests++;
            if (err_code_o !== 3'b000) begin
               failed++;
               $display("FAIL corrupt_early: got %b expected 000", err_code_o);
            end
            chk_err_next = 1'b1;
         end
         if (yumi_o && recv_o == 32'(items_lp - 1)) begin
            tests++;
            if (done_o !== 1'b0) begin
               failed++;
               $display("FAIL done_early: got %0b expected 0", done_o);
            end
            tick();
            tests++;
            if (done_o !== 1'b1) begin
               failed++;
               $display("FAIL done_rise: got %0b expected 1", done_o);
            end
            finished = 1'b1;
         end else begin
            tick();
         end
      end
      if (!finished) begin
         tests++;
         failed++;
         $display("FAIL run_timeout: got recv=%0d expected %0d", recv_o, items_lp);
      end
      tests++;
      if (sent_o !== 32'(items_lp) || recv_o !== 32'(items_lp)) begin
         failed++;
         $display("FAIL final_counts: got sent=%0d recv=%0d expected %0d %0d", sent_o, recv_o, items_lp, items_lp);
      end
      tests++;
      if (err_code_o !== exp_err || error_o !== (|exp_err)) begin
         failed++;
         $display("FAIL final_err: got err=%b error=%0b expected %b %0b", err_code_o, error_o, exp_err, |exp_err);
      end
      tests++;
      if (exp_q.size() != 0) begin
         failed++;
         $display("FAIL missing_enq: got %0d left expected 0", exp_q.size());
      end
   endtask

   task automatic test_full_rate();
      run_stream(-1, 3'b000);
      // A start pulse in DONE is ignored
      pulse_start();
      tick();
      tests++;
      if (done_o !== 1'b1 || sent_o !== 32'(items_lp) || v_o !== 1'b0) begin
         failed++;
         $display("FAIL start_in_done: got done=%0b sent=%0d v=%0b expected 1 %0d 0", done_o, sent_o, v_o, items_lp);
      end
   endtask

   task automatic test_corrupt();
      run_stream(2, 3'b001);
   endtask

   task automatic test_underflow();
      do_reset();
      pulse_start();
      tests++;
      if (err_code_o !== 3'b000) begin
         failed++;
         $display("FAIL underflow_pre: got %b expected 000", err_code_o);
      end
      spur_v = 1'b1;
      tick();
      spur_v = 1'b0;
      tests++;
      if (err_code_o !== 3'b010 || error_o !== 1'b1) begin
         failed++;
         $display("FAIL underflow_flag: got err=%b error=%0b expected 010 1", err_code_o, error_o);
      end
      do_reset();
      tests++;
      if (err_code_o !== 3'b000 || error_o !== 1'b0) begin
         failed++;
         $display("FAIL sticky_clear: got err=%b error=%0b expected 000 0", err_code_o, error_o);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      block_v = 1'b1;
      pulse_start();
      for (int cyc = 0; cyc < 20 && cnt != 2'd2; cyc++)
         tick();
      tests++;
      if (cnt != 2'd2 || v_o !== 1'b0 || err_code_o !== 3'b000) begin
         failed++;
         $display("FAIL overflow_setup: got cnt=%0d v=%0b err=%b expected 2 0 000", cnt, v_o, err_code_o);
      end
      force_rdy = 1'b1;
      #1;
      tests++;
      if (v_o !== 1'b1) begin
         failed++;
         $display("FAIL forced_ready_enq: got %0b expected 1", v_o);
      end
      tick();
      force_rdy = 1'b0;
      tests++;
      if (err_code_o !== 3'b100 || error_o !== 1'b1) begin
         failed++;
         $display("FAIL overflow_flag: got err=%b error=%0b expected 100 1", err_code_o, error_o);
      end
      do_reset();
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      pulse_start();
      for (int cyc = 0; cyc < 50 && sent_o != 32'd5; cyc++)
         tick();
      tests++;
      if (sent_o !== 32'd5) begin
         failed++;
         $display("FAIL mid_run_reach: got sent=%0d expected 5", sent_o);
      end
      reset_i = 1'b1;
      tick();
      tests++;
      if ({v_o, yumi_o, done_o, error_o, err_code_o} !== 7'b0 || sent_o !== 32'd0 ||
          recv_o !== 32'd0 || data_o !== 8'h00) begin
         failed++;
         $display("FAIL mid_run_reset: got ctrl=%b sent=%0d recv=%0d data=%0h expected 0 0 0 0",
                  {v_o, yumi_o, done_o, error_o, err_code_o}, sent_o, recv_o, data_o);
      end
      reset_i = 1'b0;
      tick();
      tests++;
      if (v_o !== 1'b0 || sent_o !== 32'd0) begin
         failed++;
         $display("FAIL mid_run_idle: got v=%0b sent=%0d expected 0 0", v_o, sent_o);
      end
      pulse_start();
      tests++;
      if (v_o !== 1'b1 || data_o !== 8'h00) begin
         failed++;
         $display("FAIL restart_data: got v=%0b data=%0h expected 1 0", v_o, data_o);
      end
      tick();
      tests++;
      if (sent_o !== 32'd1 || data_o !== 8'h01) begin
         failed++;
         $display("FAIL restart_step: got sent=%0d data=%0h expected 1 1", sent_o, data_o);
      end
      do_reset();
   endtask

   initial begin
      reset_i = 1'b1;
      start_i = 1'b0;
      tick();
      test_reset();
      test_full_rate();
      test_corrupt();
      test_underflow();
      test_overflow();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/bsg_fifo_traffic_gen.md
# bsg_fifo_traffic_gen

Synthesizable closed-loop traffic generator that drives both ends of a ready-then-valid FIFO such as bsg_two_fifo. It is the active counterpart to the FIFO's passive assertion monitor: it enqueues a sequence-numbered stream, dequeues with valid-then-yumi, and checks ordering and occupancy against its own model. It sits in the FIFO formal and simulation harness next to the DUT and monitor, and gives the monitor a bounded, reproducible stimulus source.

## Interface
- width_p, 8, data width; must equal DUT width.
- els_p, 2, DUT capacity used by the occupancy model.
- num_items_p, 16, items per run; at least 1.
- seed_p, 16'hACE1, LFSR seed; must be nonzero.
- clk_i  input  1  clock.
- reset_i  input  1  synchronous, active-high reset.
- start_i  input  1  one-cycle pulse; begins a run from IDLE.
- ready_i  input  1  DUT ready_o; enqueue permitted.
- v_o  output  1  DUT v_i; enqueue request.
- data_o  output  width_p  DUT data_i.
- v_i  input  1  DUT v_o; data available.
- data_i  input  width_p  DUT data_o.
- yumi_o  output  1  DUT yumi_i; dequeue.
- done_o  output  1  run finished; high in DONE.
- error_o  output  1  sticky OR of err_code_o.
- err_code_o  output  3  sticky flags: [0] data mismatch, [1] underflow, [2] overflow.
- sent_o  output  32  items enqueued.
- recv_o  output  32  items dequeued.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start_i.
  - RUN -> DRAIN on the edge where sent reaches num_items_p.
  - DRAIN -> DONE on the edge where recv reaches num_items_p.
  - DONE holds until reset_i.
- Enqueue: v_o = (state==RUN) & ready_i & prod_ok.
  - v_o never asserts while ready_i is low.
  - The transfer is enq = v_o. On enq, sent increments.
- Data pattern: data_o = sent[width_p-1:0]. It wraps modulo 2^width_p.
- Dequeue: yumi_o = (state==RUN or DRAIN) & v_i & cons_ok.
  - On yumi_o, data_i is compared with recv[width_p-1:0]. A mismatch sets err[0].
  - recv increments on yumi_o.
- Occupancy model: occ, width $clog2(els_p+1), reset to 0.
  - enq only: occ+1. yumi only: occ-1. Both or neither: occ unchanged.
- Model checks:
  - v_i high while occ==0 sets err[1].
  - enq while occ==els_p sets err[2].
  - Checks run in every non-IDLE state.
  - Traffic continues after an error.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, loaded with seed_p on reset. It advances every cycle in RUN and DRAIN. prod_ok = bit0 and cons_ok = bit1 (with throttling compiled in).
- Counters are 32-bit and do not saturate. sent never exceeds num_items_p.

## Timing
- Reset values: v_o=0, yumi_o=0, done_o=0, error_o=0, err_code_o=0, sent_o=0, recv_o=0, data_o=0, occ=0, state IDLE, LFSR=seed_p.
- reset_i overrides start_i and resets everything mid-run, including sticky errors. The DUT must be reset in the same cycle.
- v_o and yumi_o are combinational from ready_i and v_i, gated by registered state. There is no combinational path from ready_i to yumi_o or from v_i to v_o.
- First possible enqueue is the cycle after start_i.
- A simultaneous enq and yumi in one cycle is legal and leaves occ unchanged.
- start_i is ignored outside IDLE.
- With num_items_p=1, the state is RUN for one enqueue, then DRAIN.
- done_o rises the cycle after the final yumi_o.
- error_o is registered. It goes high the cycle after the offending edge.

## Configuration
- BSG_FIFO_TRAFFIC_GEN_THROTTLE_EN
  - Defined: prod_ok and cons_ok come from LFSR bits 0 and 1, giving randomized backpressure and bubbles.
  - Undefined: prod_ok = cons_ok = 1 (full-rate streaming). The LFSR is still present but unused.

## Test plan
- Full rate (macro undefined), els_p=2, num_items_p=16, correct bsg_two_fifo: start_i at cycle 1. Required: data_o 0..15 in order, sent_o=recv_o=16, done_o=1, error_o=0.
- Throttled (macro defined), seed 16'hACE1, num_items_p=300, width_p=8: data wraps 255->0. Required: recv_o=300, err_code_o=0, occ never above 2.
- Corrupted DUT (bit 0 of the data inverted on the 3rd dequeue): err_code_o=3'b001 one cycle after that yumi_o. Run still completes with recv_o=16.
- Spurious v_i asserted while occ==0: err_code_o[1] set the following cycle, error_o=1.
- Ready stuck high with the DUT holding 2 items and no dequeue: enqueue while occ==2 sets err_code_o[2].
- Reset mid-run (reset_i at sent_o=5): the next cycle shows all outputs at reset values and the state is IDLE. A new start_i restarts with data_o=0.
